fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequencer for the two-stage fetch front end. It owns the fetch PC, issues in-order requests to instruction memory through a request/ready handshake, and tracks outstanding responses. It also generates the stall/flush controls for the F1→F2 pipeline register and discards stale responses after a redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
MAX_OUTST, 2, maximum in-flight imem requests (1..3)
CNT_W, 2, width of outstanding/drop counters (must hold MAX_OUTST)

Ports:
clk  in  1  clock
nrst  in  1  reset; one clock; asynchronous, active-low
redirect_valid  in  1  EX branch/jump taken this cycle
redirect_pc  in  32  redirect target
dec_stall  in  1  decode back-pressure
imem_ready  in  1  imem accepts request this cycle
imem_rvalid  in  1  imem returns one response (in order)
imem_req  out  1  fetch request valid
pc_out  out  32  fetch address (to imem and F1/F2 register pc input)
f1f2_stall  out  1  hold F1/F2 register
f1f2_flush  out  1  insert bubble in F1/F2 register
rsp_keep  out  1  current imem response is live (0 = drop)
busy_drain  out  1  high in DRAIN state
proto_err  out  1  sticky: rvalid seen with zero outstanding

Behaviour:
- Reset (nrst low, async): state=BOOT, pc=RESET_PC, outst=0, drop_cnt=0, proto_err=0. Comb outputs at reset: imem_req=0, f1f2_flush=1, f1f2_stall=0, rsp_keep=0, busy_drain=0.
- FSM states: BOOT, RUN, DRAIN.
  - BOOT → RUN unconditionally after one cycle. Covers the first clock after reset release.
  - RUN → DRAIN on redirect_valid when next_drop > 0.
  - DRAIN → RUN when drop_cnt reaches 0 (including via a decrement in the same cycle).
  - A redirect in DRAIN reloads drop_cnt and stays in DRAIN, or goes to RUN if next_drop = 0.
- imem_req = (state==RUN) && !redirect_valid && !dec_stall && (outst < MAX_OUTST).
- accept = imem_req && imem_ready. On accept: pc <= pc + 4, wrapping mod 2^32.
- Redirect has highest priority over accept and dec_stall:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - next_drop = outst - (imem_rvalid ? 1 : 0); drop_cnt <= next_drop.
- outst update: +1 on accept, -1 on rvalid, unchanged if both; saturates at 0.
- rvalid with outst==0 sets proto_err and does not change counters.
- rsp_keep = imem_rvalid && (drop_cnt==0) && (state!=BOOT). A dropped response (drop_cnt>0) decrements drop_cnt.
- pc_out = current pc register, combinational, zero latency.
- f1f2_flush = redirect_valid || (state!=RUN) || (!dec_stall && !accept).
- f1f2_stall = dec_stall && !f1f2_flush. Flush always dominates stall.
- Redirect coincident with dec_stall: flush=1, stall=0, pc reloads.
- Redirect with outst==0: no DRAIN; RUN continues and issues on the next cycle.
- imem_ready high while imem_req low has no effect.
- Async reset mid-DRAIN: all state cleared. Responses arriving after reset with outst==0 set proto_err.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_e
  - localparam PC_STEP = 32'd4
  - typedef logic [31:0] addr_t
- One natural sub-module: fetch_outst_cnt (up/down counter with saturation and error flag), instantiated for outst. drop_cnt stays inline.

Test Plan:
1. Reset release, imem_ready=1, rvalid one cycle after accept → BOOT then RUN; pc_out 0x0,0x4,0x8; flush high during BOOT only; rsp_keep=1 on every response.
2. dec_stall held 3 cycles at pc=0x10 → imem_req=0, f1f2_stall=1, pc_out stays 0x10; resumes 0x14 after release.
3. imem_ready=0 for 2 cycles, MAX_OUTST=2 with no responses → at most 2 accepts; then imem_req=0 and f1f2_flush=1 (bubble) until rvalid.
4. Redirect to 0x1003 with outst=2, no rvalid → pc_out=0x1000; state DRAIN; next two responses rsp_keep=0; then RUN and issue at 0x1000.
5. Redirect coincident with rvalid and dec_stall, outst=1 → drop_cnt=0, no DRAIN; flush=1, stall=0; pc reloads.
6. rvalid with outst=0; async nrst pulse mid-DRAIN → proto_err=1 sticky; on reset, pc=RESET_PC, state BOOT, proto_err cleared.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: FSM states, PC step and address type.
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_e;
    localparam logic [31:0] PC_STEP = 32'd4;
    typedef logic [31:0] addr_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the fetch sequencer and its imem / pipeline neighbours.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic  redirect_valid;
    addr_t redirect_pc;
    logic  dec_stall;
    logic  imem_ready;
    logic  imem_rvalid;
    logic  imem_req;
    addr_t pc_out;
    logic  f1f2_stall;
    logic  f1f2_flush;
    logic  rsp_keep;
    logic  busy_drain;
    logic  proto_err;

    modport master (
        input  redirect_valid, redirect_pc, dec_stall, imem_ready, imem_rvalid,
        output imem_req, pc_out, f1f2_stall, f1f2_flush, rsp_keep, busy_drain, proto_err
    );

    modport slave (
        output redirect_valid, redirect_pc, dec_stall, imem_ready, imem_rvalid,
        input  imem_req, pc_out, f1f2_stall, f1f2_flush, rsp_keep, busy_drain, proto_err
    );
endinterface

// File: rtl/fetch_outst_cnt.sv
// Saturating up/down counter of in-flight requests with a sticky underflow flag.
// Simultaneous inc/dec leaves the count unchanged; dec at zero only raises err.
module fetch_outst_cnt #(
    parameter int MAX = 2,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         err
);
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (dec && cnt == '0)
                err <= 1'b1;
            if (inc && !dec && cnt != W'(MAX))
                cnt <= cnt + W'(1);
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - W'(1);
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues in-order imem requests, drops stale
// responses after a redirect and drives F1/F2 stall/flush.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC  = 32'h0000_0000,
    parameter int    MAX_OUTST = 2,
    parameter int    CNT_W     = 2
) (
    input  logic clk,
    input  logic nrst,
    fetch_ctrl_if.master io
);
    fetch_state_e     state, state_nx;
    addr_t            pc;
    logic [CNT_W-1:0] outst;
    logic [CNT_W-1:0] drop_cnt, drop_dec, drop_nx, next_drop;
    logic             req, accept, err;

    assign req    = (state == RUN) && !io.redirect_valid && !io.dec_stall &&
                    (outst < CNT_W'(MAX_OUTST));
    assign accept = req && io.imem_ready;

    // Responses still owed after this cycle's response (if any) become stale on redirect.
    assign next_drop = (io.imem_rvalid && outst != '0) ? outst - CNT_W'(1) : outst;
    assign drop_dec  = (io.imem_rvalid && drop_cnt != '0) ? drop_cnt - CNT_W'(1) : drop_cnt;
    assign drop_nx   = io.redirect_valid ? next_drop : drop_dec;

    fetch_outst_cnt #(.MAX(MAX_OUTST), .W(CNT_W)) u_outst (
        .clk  (clk),
        .nrst (nrst),
        .inc  (accept),
        .dec  (io.imem_rvalid),
        .cnt  (outst),
        .err  (err)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            state    <= state_nx;
            drop_cnt <= drop_nx;
            if (io.redirect_valid)
                pc <= {io.redirect_pc[31:2], 2'b00};
            else if (accept)
                pc <= pc + PC_STEP;
        end
    end

    always_comb begin
        state_nx      = state;
        io.f1f2_flush = 1'b0;
        io.f1f2_stall = 1'b0;
        io.rsp_keep   = 1'b0;
        io.busy_drain = 1'b0;

        case (state)
            BOOT:    state_nx = RUN;
            RUN:     if (io.redirect_valid && next_drop != '0) state_nx = DRAIN;
            DRAIN:   if (drop_nx == '0) state_nx = RUN;
            default: state_nx = BOOT;
        endcase

        io.f1f2_flush = io.redirect_valid || (state != RUN) || (!io.dec_stall && !accept);
        io.f1f2_stall = io.dec_stall && !io.f1f2_flush;
        io.rsp_keep   = io.imem_rvalid && (drop_cnt == '0) && (state != BOOT);
        io.busy_drain = (state == DRAIN);
    end

    assign io.imem_req  = req;
    assign io.pc_out    = pc;
    assign io.proto_err = err;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based reference of in-flight requests.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int MAX = 2;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0), .MAX_OUTST(MAX), .CNT_W(2)) dut (
        .clk  (clk),
        .nrst (nrst),
        .io   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference: each in-flight request is one queue entry, 1 = stale (issued before a redirect).
    bit          m_boot;
    logic [31:0] m_pc;
    bit          q[$];
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_stale();
        foreach (q[i]) if (q[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_run();
        return !m_boot && !m_stale();
    endfunction

    function automatic bit m_req();
        return m_run() && !bus.redirect_valid && !bus.dec_stall && (q.size() < MAX);
    endfunction

    task automatic check_outs(input string ph);
        bit req, acc, flush, stall, keep;
        req   = m_req();
        acc   = req && bus.imem_ready;
        flush = bus.redirect_valid || !m_run() || (!bus.dec_stall && !acc);
        stall = bus.dec_stall && !flush;
        keep  = bus.imem_rvalid && !m_boot && (q.size() == 0 || !q[0]);
        chk({ph, "_req"},   32'(bus.imem_req),   32'(req));
        chk({ph, "_pc"},    bus.pc_out,          m_pc);
        chk({ph, "_flush"}, 32'(bus.f1f2_flush), 32'(flush));
        chk({ph, "_stall"}, 32'(bus.f1f2_stall), 32'(stall));
        chk({ph, "_keep"},  32'(bus.rsp_keep),   32'(keep));
        chk({ph, "_drain"}, 32'(bus.busy_drain), 32'(!m_boot && m_stale()));
        chk({ph, "_perr"},  32'(bus.proto_err),  32'(m_err));
    endtask

    task automatic step(input string ph, input bit rd, input logic [31:0] rpc,
                        input bit ds, input bit rdy, input bit rv);
        bit acc;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rpc;
        bus.dec_stall      = ds;
        bus.imem_ready     = rdy;
        bus.imem_rvalid    = rv;
        #1;
        check_outs(ph);
        acc = m_req() && rdy;
        @(posedge clk);
        if (rv) begin
            if (q.size() == 0) m_err = 1'b1;
            else void'(q.pop_front());
        end
        if (rd) begin
            foreach (q[i]) q[i] = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end else if (acc) begin
            m_pc = m_pc + 32'd4;
        end
        if (acc) q.push_back(1'b0);
        m_boot = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        nrst               = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.dec_stall      = 1'b0;
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        #2;
        m_boot = 1'b1;
        m_pc   = 32'h0;
        q.delete();
        m_err  = 1'b0;
        check_outs("rst");
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Boot, then back-to-back issue with responses one cycle later.
        step("t1", 0, 0, 0, 1, 0);
        step("t1", 0, 0, 0, 1, 0);
        step("t1", 0, 0, 0, 1, 1);
        step("t1", 0, 0, 0, 1, 1);
        chk("t1_pc_c", bus.pc_out, 32'hC);

        // Decode stall holds the PC.
        step("t2", 0, 0, 0, 1, 1);
        step("t2", 0, 0, 1, 1, 1);
        step("t2", 0, 0, 1, 1, 0);
        step("t2", 0, 0, 1, 1, 0);
        chk("t2_hold", bus.pc_out, 32'h10);
        step("t2", 0, 0, 0, 1, 0);
        chk("t2_resume", bus.pc_out, 32'h14);

        // Outstanding limit reached with no responses.
        step("t3", 0, 0, 0, 1, 0);
        step("t3", 0, 0, 0, 0, 0);
        step("t3", 0, 0, 0, 0, 0);
        step("t3", 0, 0, 0, 1, 0);
        chk("t3_req_full", 32'(bus.imem_req), 32'd0);
        chk("t3_pc", bus.pc_out, 32'h18);

        // Redirect with two in flight: both responses dropped.
        step("t4", 1, 32'h1003, 0, 1, 0);
        chk("t4_pc", bus.pc_out, 32'h1000);
        chk("t4_drain", 32'(bus.busy_drain), 32'd1);
        step("t4", 0, 0, 0, 1, 1);
        step("t4", 0, 0, 0, 1, 1);
        step("t4", 0, 0, 0, 1, 0);
        chk("t4_issue", bus.pc_out, 32'h1004);

        // Redirect + rvalid + dec_stall with one in flight: no drain.
        step("t5", 1, 32'h2000, 1, 1, 1);
        chk("t5_nodrain", 32'(bus.busy_drain), 32'd0);
        chk("t5_pc", bus.pc_out, 32'h2000);

        for (int i = 0; i < 3000; i++) begin
            step("rnd", ($urandom_range(0, 11) == 0), $urandom, ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), (q.size() > 0) && ($urandom_range(0, 1) == 1));
        end

        // Protocol error and async reset in the middle of a drain.
        do_reset();
        step("t6", 0, 0, 0, 0, 0);
        step("t6", 0, 0, 0, 0, 1);
        chk("t6_perr", 32'(bus.proto_err), 32'd1);
        step("t6", 0, 0, 0, 1, 0);
        step("t6", 0, 0, 0, 1, 0);
        step("t6", 1, 32'h3000, 0, 1, 0);
        chk("t6_in_drain", 32'(bus.busy_drain), 32'd1);
        do_reset();
        chk("t6_rst_pc", bus.pc_out, 32'h0);
        step("t6", 0, 0, 0, 0, 0);
        step("t6", 0, 0, 0, 0, 1);
        chk("t6_perr_again", 32'(bus.proto_err), 32'd1);
        step("t6", 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
